// File: rtl/load_store_unit.sv
// Load/store initiator for the byte-addressable data bus: aligns requests to words,
// splits word-crossing accesses into two beats and returns one extended response.
module load_store_unit #(
  parameter int ADDR_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_resp_valid,
  output logic [31:0]       o_resp_rdata,
  output logic              o_resp_err,
  output logic              o_mem_req,
  input  logic              i_mem_gnt,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [3:0]        o_mem_be,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_rvalid,
  input  logic [31:0]       i_mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_BEAT0, S_WAIT0, S_BEAT1, S_WAIT1, S_RESP
  } state_t;

  state_t      r_state;
  logic        r_we;
  logic        r_split;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [3:0]  r_be_hi;
  logic [31:0] r_wd_hi;
  logic [31:0] r_rd_lo;

  logic        w_size_b;
  logic        w_size_h;
  logic        w_misal;
  logic [1:0]  w_off;
  logic [3:0]  w_mask;
  logic [7:0]  w_be8;
  logic [63:0] w_wd64;
  logic [63:0] w_rd64;
  logic [31:0] w_rd32;
  logic [31:0] w_ld_data;

  // bu/hu encodings only mean a narrow access for loads; for stores they fall back to a word
  assign w_size_b = (i_req_funct3 == 3'd0) || (!i_req_we && i_req_funct3 == 3'd4);
  assign w_size_h = (i_req_funct3 == 3'd1) || (!i_req_we && i_req_funct3 == 3'd5);
  assign w_off    = i_req_addr[1:0];
  assign w_mask   = w_size_b ? 4'b0001 : (w_size_h ? 4'b0011 : 4'b1111);
  assign w_misal  = w_size_h ? w_off[0] : (!w_size_b && (w_off != 2'd0));

  // Low half feeds the first beat, high half is held for the second beat
  assign w_be8  = {4'b0000, w_mask} << w_off;
  assign w_wd64 = {32'h0, i_req_wdata} << {w_off, 3'b000};

  assign w_rd64 = (r_state == S_WAIT1) ? {i_mem_rdata, r_rd_lo} : {32'h0, i_mem_rdata};
  assign w_rd32 = w_rd64[{1'b0, r_off, 3'b000} +: 32];

  always_comb begin
    w_ld_data = w_rd32;
    case (r_f3)
      3'd0:    w_ld_data = {{24{w_rd32[7]}}, w_rd32[7:0]};
      3'd1:    w_ld_data = {{16{w_rd32[15]}}, w_rd32[15:0]};
      3'd4:    w_ld_data = {24'h0, w_rd32[7:0]};
      3'd5:    w_ld_data = {16'h0, w_rd32[15:0]};
      default: w_ld_data = w_rd32;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_split      <= 1'b0;
      r_f3         <= 3'd0;
      r_off        <= 2'd0;
      r_be_hi      <= 4'd0;
      r_wd_hi      <= 32'h0;
      r_rd_lo      <= 32'h0;
      o_req_ready  <= 1'b1;
      o_resp_valid <= 1'b0;
      o_resp_rdata <= 32'h0;
      o_resp_err   <= 1'b0;
      o_mem_req    <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_be     <= 4'd0;
      o_mem_wdata  <= 32'h0;
    end else begin
      o_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            o_req_ready <= 1'b0;
            r_we        <= i_req_we;
            r_f3        <= i_req_funct3;
            r_off       <= w_off;
            r_split     <= (w_be8[7:4] != 4'd0);
            r_be_hi     <= w_be8[7:4];
            r_wd_hi     <= w_wd64[63:32];
            if (w_misal && !ALLOW_MISALIGNED) begin
              r_state      <= S_RESP;
              o_resp_valid <= 1'b1;
              o_resp_err   <= 1'b1;
              o_resp_rdata <= 32'h0;
            end else begin
              r_state     <= S_BEAT0;
              o_mem_req   <= 1'b1;
              o_mem_we    <= i_req_we;
              o_mem_addr  <= {i_req_addr[ADDR_W-1:2], 2'b00};
              o_mem_be    <= w_be8[3:0];
              o_mem_wdata <= w_wd64[31:0];
            end
          end
        end
        S_BEAT0: begin
          if (i_mem_gnt) begin
            if (!r_we) begin
              o_mem_req <= 1'b0;
              r_state   <= S_WAIT0;
            end else if (r_split) begin
              o_mem_addr  <= o_mem_addr + ADDR_W'(4);
              o_mem_be    <= r_be_hi;
              o_mem_wdata <= r_wd_hi;
              r_state     <= S_BEAT1;
            end else begin
              o_mem_req    <= 1'b0;
              o_resp_valid <= 1'b1;
              o_resp_rdata <= 32'h0;
              r_state      <= S_RESP;
            end
          end
        end
        S_WAIT0: begin
          if (i_mem_rvalid) begin
            if (r_split) begin
              r_rd_lo     <= i_mem_rdata;
              o_mem_req   <= 1'b1;
              o_mem_addr  <= o_mem_addr + ADDR_W'(4);
              o_mem_be    <= r_be_hi;
              o_mem_wdata <= r_wd_hi;
              r_state     <= S_BEAT1;
            end else begin
              o_resp_valid <= 1'b1;
              o_resp_rdata <= w_ld_data;
              r_state      <= S_RESP;
            end
          end
        end
        S_BEAT1: begin
          if (i_mem_gnt) begin
            o_mem_req <= 1'b0;
            if (!r_we) begin
              r_state <= S_WAIT1;
            end else begin
              o_resp_valid <= 1'b1;
              o_resp_rdata <= 32'h0;
              r_state      <= S_RESP;
            end
          end
        end
        S_WAIT1: begin
          if (i_mem_rvalid) begin
            o_resp_valid <= 1'b1;
            o_resp_rdata <= w_ld_data;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          o_resp_err   <= 1'b0;
          o_resp_rdata <= 32'h0;
          o_req_ready  <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected beats/responses,
// a negedge monitor pops and compares, a small responder models the bus.
module tb_load_store_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        d0_req_valid, d0_req_ready, d0_req_we;
  logic [2:0]  d0_req_funct3;
  logic [31:0] d0_req_addr, d0_req_wdata;
  logic        d0_resp_valid, d0_resp_err;
  logic [31:0] d0_resp_rdata;
  logic        d0_mem_req, d0_mem_gnt, d0_mem_we, d0_mem_rvalid;
  logic [31:0] d0_mem_addr, d0_mem_wdata, d0_mem_rdata;
  logic [3:0]  d0_mem_be;

  load_store_unit #(.ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_funct3(req_funct3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
    .o_mem_req(mem_req), .i_mem_gnt(mem_gnt), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_be(mem_be), .o_mem_wdata(mem_wdata),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
  );

  load_store_unit #(.ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) u_dut_strict (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(d0_req_valid), .o_req_ready(d0_req_ready), .i_req_we(d0_req_we),
    .i_req_funct3(d0_req_funct3), .i_req_addr(d0_req_addr), .i_req_wdata(d0_req_wdata),
    .o_resp_valid(d0_resp_valid), .o_resp_rdata(d0_resp_rdata), .o_resp_err(d0_resp_err),
    .o_mem_req(d0_mem_req), .i_mem_gnt(d0_mem_gnt), .o_mem_we(d0_mem_we),
    .o_mem_addr(d0_mem_addr), .o_mem_be(d0_mem_be), .o_mem_wdata(d0_mem_wdata),
    .i_mem_rvalid(d0_mem_rvalid), .i_mem_rdata(d0_mem_rdata)
  );

  typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; } beat_t;
  typedef struct { logic [31:0] rdata; logic err; int lat; } resp_t;

  beat_t       bq[$];
  resp_t       rq[$];
  resp_t       rq0[$];
  logic [31:0] rdq[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int gnt_delay = 0;
  int wait_cnt = 0;
  int rd_req_cnt = 0, rd_done_cnt = 0;
  int stray_req_cnt = 0, stray_done_cnt = 0;
  int resp_seen = 0;
  int d0_req_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] be);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  // Bus responder: grant after gnt_delay wait cycles, read data the cycle after grant
  always @(posedge clk) begin
    #1;
    mem_rvalid = 1'b0;
    if (rd_req_cnt != rd_done_cnt) begin
      rd_done_cnt++;
      mem_rvalid = 1'b1;
      mem_rdata  = (rdq.size() != 0) ? rdq.pop_front() : 32'h0;
    end else if (stray_req_cnt != stray_done_cnt) begin
      stray_done_cnt++;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h12345678;
    end
    if (mem_req && rst_n) begin
      if (wait_cnt >= gnt_delay) begin
        mem_gnt  = 1'b1;
        wait_cnt = 0;
      end else begin
        mem_gnt = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_gnt  = 1'b0;
      wait_cnt = 0;
    end
  end

  int          acc_cyc = 0, acc0_cyc = 0;
  logic        hold_v = 1'b0;
  logic [31:0] h_addr, h_wdata;
  logic [3:0]  h_be;

  always @(negedge clk) begin : mon
    beat_t b;
    resp_t r;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (req_valid && req_ready) acc_cyc = cyc;
      if (d0_req_valid && d0_req_ready) acc0_cyc = cyc;
      if (mem_req) begin
        if (hold_v) begin
          chk("hold_addr", mem_addr, h_addr);
          chk("hold_be", {28'h0, mem_be}, {28'h0, h_be});
          chk("hold_wdata", mem_wdata, h_wdata);
        end
        if (mem_gnt) begin
          hold_v = 1'b0;
          if (bq.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL beat_unexpected: addr 0x%08h be %b, none expected", mem_addr, mem_be);
          end else begin
            b = bq.pop_front();
            chk("beat_addr", mem_addr, b.addr);
            chk("beat_be", {28'h0, mem_be}, {28'h0, b.be});
            chk("beat_we", {31'h0, mem_we}, {31'h0, b.we});
            if (b.we) chk("beat_wdata", mem_wdata & lanes(mem_be), b.wdata & lanes(b.be));
          end
          if (!mem_we) rd_req_cnt++;
        end else begin
          hold_v  = 1'b1;
          h_addr  = mem_addr;
          h_be    = mem_be;
          h_wdata = mem_wdata;
        end
      end else begin
        hold_v = 1'b0;
      end
      if (resp_valid) begin
        resp_seen++;
        if (rq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL resp_unexpected: rdata 0x%08h err %b, none expected", resp_rdata, resp_err);
        end else begin
          r = rq.pop_front();
          chk("resp_rdata", resp_rdata, r.rdata);
          chk("resp_err", {31'h0, resp_err}, {31'h0, r.err});
          chk("resp_latency", cyc - acc_cyc, r.lat);
        end
      end
      if (d0_mem_req) d0_req_cycles++;
      if (d0_resp_valid) begin
        if (rq0.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL strict_resp_unexpected: rdata 0x%08h err %b", d0_resp_rdata, d0_resp_err);
        end else begin
          r = rq0.pop_front();
          chk("strict_rdata", d0_resp_rdata, r.rdata);
          chk("strict_err", {31'h0, d0_resp_err}, {31'h0, r.err});
          chk("strict_latency", cyc - acc0_cyc, r.lat);
        end
      end
    end
  end

  task automatic exp_beat(input logic [31:0] a, input logic [3:0] be, input logic we, input logic [31:0] wd);
    bq.push_back('{a, be, we, wd});
  endtask

  task automatic exp_resp(input logic [31:0] rd, input logic err, input int lat);
    rq.push_back('{rd, err, lat});
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int t;
    t = 0;
    @(posedge clk); #1;
    while (!req_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("req_ready_before_issue", {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((bq.size() != 0 || rq.size() != 0) && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk("drain_pending", bq.size() + rq.size(), 32'h0);
    bq.delete();
    rq.delete();
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int t;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    d0_req_valid = 1'b0; d0_req_we = 1'b0; d0_req_funct3 = 3'd0; d0_req_addr = 32'h0;
    d0_req_wdata = 32'h0; d0_mem_gnt = 1'b0; d0_mem_rvalid = 1'b0; d0_mem_rdata = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_be", {28'h0, mem_be}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    rst_n = 1'b1;

    // lw aligned
    exp_beat(32'h100, 4'b1111, 1'b0, 32'h0); rdq.push_back(32'hDEADBEEF);
    exp_resp(32'hDEADBEEF, 1'b0, 3);
    issue(1'b0, 3'd2, 32'h100, 32'h0); wait_done();
    // lb / lbu top lane
    exp_beat(32'h100, 4'b1000, 1'b0, 32'h0); rdq.push_back(32'h80123456);
    exp_resp(32'hFFFFFF80, 1'b0, 3);
    issue(1'b0, 3'd0, 32'h103, 32'h0); wait_done();
    exp_beat(32'h100, 4'b1000, 1'b0, 32'h0); rdq.push_back(32'h80123456);
    exp_resp(32'h00000080, 1'b0, 3);
    issue(1'b0, 3'd4, 32'h103, 32'h0); wait_done();
    // split lw
    exp_beat(32'h100, 4'b1100, 1'b0, 32'h0); rdq.push_back(32'h5678AAAA);
    exp_beat(32'h104, 4'b0011, 1'b0, 32'h0); rdq.push_back(32'hBBBB1234);
    exp_resp(32'h12345678, 1'b0, 5);
    issue(1'b0, 3'd2, 32'h102, 32'h0); wait_done();
    // split sh
    exp_beat(32'h200, 4'b1000, 1'b1, 32'hCD000000);
    exp_beat(32'h204, 4'b0001, 1'b1, 32'h000000AB);
    exp_resp(32'h0, 1'b0, 3);
    issue(1'b1, 3'd1, 32'h203, 32'h0000ABCD); wait_done();
    // sw with grant held off for 5 cycles
    gnt_delay = 5;
    exp_beat(32'h300, 4'b1111, 1'b1, 32'h11223344);
    exp_resp(32'h0, 1'b0, 7);
    issue(1'b1, 3'd2, 32'h300, 32'h11223344); wait_done();
    gnt_delay = 0;
    // lh / lhu upper half
    exp_beat(32'h104, 4'b1100, 1'b0, 32'h0); rdq.push_back(32'h80015555);
    exp_resp(32'hFFFF8001, 1'b0, 3);
    issue(1'b0, 3'd1, 32'h106, 32'h0); wait_done();
    exp_beat(32'h104, 4'b1100, 1'b0, 32'h0); rdq.push_back(32'h80015555);
    exp_resp(32'h00008001, 1'b0, 3);
    issue(1'b0, 3'd5, 32'h106, 32'h0); wait_done();
    // sb aligned store, minimum store latency
    exp_beat(32'h400, 4'b0010, 1'b1, 32'h0000A500);
    exp_resp(32'h0, 1'b0, 2);
    issue(1'b1, 3'd0, 32'h401, 32'h000000A5); wait_done();
    // split lw wrapping the address space
    exp_beat(32'hFFFFFFFC, 4'b1100, 1'b0, 32'h0); rdq.push_back(32'hCAFE0000);
    exp_beat(32'h00000000, 4'b0011, 1'b0, 32'h0); rdq.push_back(32'h0000BEEF);
    exp_resp(32'hBEEFCAFE, 1'b0, 5);
    issue(1'b0, 3'd2, 32'hFFFFFFFE, 32'h0); wait_done();
    // misaligned but within one word
    exp_beat(32'h100, 4'b0110, 1'b0, 32'h0); rdq.push_back(32'h00ABCD00);
    exp_resp(32'hFFFFABCD, 1'b0, 3);
    issue(1'b0, 3'd1, 32'h101, 32'h0); wait_done();

    // reset while a beat is waiting for grant
    gnt_delay = 20;
    issue(1'b0, 3'd2, 32'h600, 32'h0);
    #2;
    chk("beat0_req_before_rst", {31'h0, mem_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_beat0_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_beat0_req_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    gnt_delay = 0;
    repeat (2) @(posedge clk);

    // reset in WAIT0, then the read data arrives anyway
    seen = resp_seen;
    exp_beat(32'h500, 4'b1111, 1'b0, 32'h0); rdq.push_back(32'h77777777);
    issue(1'b0, 3'd2, 32'h500, 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_wait0_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_wait0_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_wait0_resp_valid", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    stray_req_cnt++;
    repeat (6) @(posedge clk);
    #1;
    chk("no_resp_after_rst", resp_seen - seen, 32'h0);
    chk("idle_after_rst_ready", {31'h0, req_ready}, 32'h1);
    chk("idle_after_rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_beat_consumed", bq.size(), 32'h0);

    // unit still works after the abandoned transaction
    exp_beat(32'h700, 4'b1111, 1'b0, 32'h0); rdq.push_back(32'h0BADF00D);
    exp_resp(32'h0BADF00D, 1'b0, 3);
    issue(1'b0, 3'd2, 32'h700, 32'h0); wait_done();

    // strict instance: misaligned word load errors without touching the bus
    @(posedge clk); #1;
    t = 0;
    while (!d0_req_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    rq0.push_back('{32'h0, 1'b1, 1});
    d0_req_valid = 1'b1; d0_req_we = 1'b0; d0_req_funct3 = 3'd2; d0_req_addr = 32'h101;
    @(posedge clk); #1;
    d0_req_valid = 1'b0;
    t = 0;
    while (rq0.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    chk("strict_resp_seen", rq0.size(), 32'h0);
    repeat (3) @(posedge clk);
    chk("strict_no_mem_req", d0_req_cycles, 32'h0);
    chk("strict_ready_again", {31'h0, d0_req_ready}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
